sample_capture: RTL

- Front-end capture stage directly upstream of the sample memory bank.
- Takes the RF front-end's free-running sample clock (fe_clk) and 3-bit sample bus, both asynchronous to clk.
- Resynchronises them into the clk domain and emits one single-cycle data_available strobe per front-end sample, with a held 3-bit data_out.
- Supervises the front-end clock: loss detection and a sample counter for the acquisition controller.

---
 rtl/sample_capture.sv | 114 +++++++++++
 1 files changed

// File: rtl/sample_capture.sv
// Resynchronises an asynchronous front-end sample clock/bus into clk, one data_available strobe per fe_clk rise.
// Latency: fe_clk rise sampled at edge N -> strobe registered at edge N+2 (high in cycle N+3). No backpressure.
module sample_capture #(
    parameter int SAMPLE_WIDTH   = 3,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMEOUT_WIDTH  = 7,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    fe_clk,
    input  logic [SAMPLE_WIDTH-1:0] fe_data,
    input  logic                    clear_lost,
    output logic                    data_available,
    output logic [SAMPLE_WIDTH-1:0] data_out,
    output logic                    fe_lost,
    output logic                    running,
    output logic [COUNT_WIDTH-1:0]  sample_count
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, LOST} state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   state_q, state_d;
    logic                     fe_s1_q, fe_s2_q, fe_s3_q;
    logic [SAMPLE_WIDTH-1:0]  dat_s1_q, dat_s2_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
    logic [COUNT_WIDTH-1:0]   sample_count_q, sample_count_d;
    logic [SAMPLE_WIDTH-1:0]  data_out_q, data_out_d;
    logic                     dav_q, dav_d;
    logic                     lost_q, lost_d;
    logic                     set_lost;
    logic                     rise;

    assign rise = fe_s2_q & ~fe_s3_q;

    always_comb begin
        state_d        = state_q;
        tmo_d          = '0;
        sample_count_d = sample_count_q;
        data_out_d     = data_out_q;
        dav_d          = 1'b0;
        set_lost       = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = ARMED;
            end
            ARMED: begin
                // The first edge only aligns; its sample is not trusted.
                if (!enable)   state_d = IDLE;
                else if (rise) state_d = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_d        = IDLE;
                    sample_count_d = '0;
                end else if (rise) begin
                    dav_d          = 1'b1;
                    data_out_d     = dat_s2_q;
                    sample_count_d = sample_count_q + 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    set_lost       = 1'b1;
                    state_d        = LOST;
                    sample_count_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            LOST: begin
                if (!enable)   state_d = IDLE;
                else if (rise) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
        lost_d = set_lost | (lost_q & ~clear_lost);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            fe_s1_q        <= 1'b0;
            fe_s2_q        <= 1'b0;
            fe_s3_q        <= 1'b0;
            dat_s1_q       <= '0;
            dat_s2_q       <= '0;
            tmo_q          <= '0;
            sample_count_q <= '0;
            data_out_q     <= '0;
            dav_q          <= 1'b0;
            lost_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            fe_s1_q        <= fe_clk;
            fe_s2_q        <= fe_s1_q;
            fe_s3_q        <= fe_s2_q;
            dat_s1_q       <= fe_data;
            dat_s2_q       <= dat_s1_q;
            tmo_q          <= tmo_d;
            sample_count_q <= sample_count_d;
            data_out_q     <= data_out_d;
            dav_q          <= dav_d;
            lost_q         <= lost_d;
        end
    end

    assign data_available = dav_q;
    assign data_out       = data_out_q;
    assign fe_lost        = lost_q;
    assign running        = (state_q == RUN);
    assign sample_count   = sample_count_q;

endmodule
